// File: rtl/nfca_pkg.sv
// ============================================================================
// nfca_pkg : shared NFC-A transmit framing types, constants and helpers
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package nfca_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_PAR   = 3'd2,
    ST_END   = 3'd3,
    ST_UNDER = 3'd4,
    ST_DRAIN = 3'd5
  } tx_state_t;

  localparam logic NFCA_SOF_BIT = 1'b0;

  // ISO14443-A parity makes the total count of ones in byte+parity odd
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nfca_tx_frame.sv
// ============================================================================
// nfca_tx_frame : byte-stream to start/data/parity bit sequencer for the
//                 NFC-A PCD modulator, one bit per modulator tx_req pulse
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module nfca_tx_frame
  import nfca_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_tvalid,
  output logic       tx_tready,
  input  logic [7:0] tx_tdata,
  input  logic       tx_tlast,
  input  logic [2:0] tx_tdatab,
  input  logic       tx_req,
  output logic       tx_en,
  output logic       tx_bit,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  tx_state_t  state;
  logic [7:0] cur;
  logic [3:0] cnt;
  logic       cur_last;
  logic       cur_partial;
  logic       cur_par;
  logic [7:0] nxt;
  logic       nxt_valid;
  logic       nxt_last;
  logic [2:0] nxt_datab;

  logic       accept;
  logic       avail;
  logic       load;
  logic [7:0] in_data;
  logic       in_last;
  logic [2:0] in_datab;
  logic [3:0] in_bits;

  assign tx_tready = (state == ST_DRAIN) ? 1'b1 : ~nxt_valid;
  assign accept    = tx_tvalid & tx_tready;
  assign busy      = (state != ST_IDLE);

  // The byte on offer is the held one, or the one handshaking right now
  assign avail    = nxt_valid | accept;
  assign in_data  = nxt_valid ? nxt       : tx_tdata;
  assign in_last  = nxt_valid ? nxt_last  : tx_tlast;
  assign in_datab = nxt_valid ? nxt_datab : tx_tdatab;
  assign in_bits  = (in_last && (in_datab != 3'd0)) ? {1'b0, in_datab} : 4'd8;

  assign load = tx_req & avail &
                ((state == ST_IDLE) | ((state == ST_PAR) & ~cur_last));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cur         <= 8'd0;
      cnt         <= 4'd0;
      cur_last    <= 1'b0;
      cur_partial <= 1'b0;
      cur_par     <= 1'b0;
      nxt         <= 8'd0;
      nxt_valid   <= 1'b0;
      nxt_last    <= 1'b0;
      nxt_datab   <= 3'd0;
      tx_en       <= 1'b0;
      tx_bit      <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      done     <= 1'b0;
      underrun <= 1'b0;

      if (accept && (state != ST_DRAIN)) begin
        nxt       <= tx_tdata;
        nxt_last  <= tx_tlast;
        nxt_datab <= tx_tdatab;
        nxt_valid <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (tx_req) begin
            if (avail) begin
              tx_en  <= 1'b1;
              tx_bit <= NFCA_SOF_BIT;
              state  <= ST_DATA;
            end else begin
              tx_en  <= 1'b0;
              tx_bit <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (tx_req) begin
            tx_bit <= cur[0];
            cur    <= {1'b0, cur[7:1]};
            cnt    <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= cur_partial ? ST_END : ST_PAR;
            end
          end
        end
        ST_PAR: begin
          if (tx_req) begin
            tx_bit <= cur_par;
            if (cur_last)   state <= ST_END;
            else if (avail) state <= ST_DATA;
            else            state <= ST_UNDER;
          end
        end
        ST_END: begin
          if (tx_req) begin
            tx_en  <= 1'b0;
            tx_bit <= 1'b0;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_UNDER: begin
          if (tx_req) begin
            tx_en     <= 1'b0;
            tx_bit    <= 1'b0;
            underrun  <= 1'b1;
            nxt_valid <= 1'b0;
            // A frame tail that already arrived late is dropped here
            state     <= (cur_last || (avail && in_last)) ? ST_IDLE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (tx_tvalid && tx_tlast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (load) begin
        cur         <= in_data;
        cnt         <= in_bits;
        cur_last    <= in_last;
        cur_partial <= (in_bits != 4'd8);
        cur_par     <= odd_parity(in_data);
        nxt_valid   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nfca_tx_frame.sv
// Bench for nfca_tx_frame: directed and random frames against a bit-list model.
`default_nettype none

module tb_nfca_tx_frame;

  localparam int GAP = 20;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic [2:0] db;
  } hbyte_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       tx_tvalid;
  logic       tx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tlast;
  logic [2:0] tx_tdatab;
  logic       tx_req;
  logic       tx_en;
  logic       tx_bit;
  logic       busy;
  logic       done;
  logic       underrun;

  int vectors     = 0;
  int miscompares = 0;
  int stab_err    = 0;

  hbyte_t hq[$];
  hbyte_t fq[$];
  int     rd_ptr;
  logic   fired = 1'b0;

  always #5 clk = ~clk;

  nfca_tx_frame dut (
    .clk       (clk),
    .rstn      (rstn),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .tx_tdata  (tx_tdata),
    .tx_tlast  (tx_tlast),
    .tx_tdatab (tx_tdatab),
    .tx_req    (tx_req),
    .tx_en     (tx_en),
    .tx_bit    (tx_bit),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  // Host side: present queued bytes in order, advance on each handshake
  always @(posedge clk) fired <= tx_tvalid && tx_tready && rstn;

  initial begin
    tx_tvalid = 1'b0;
    tx_tdata  = 8'd0;
    tx_tlast  = 1'b0;
    tx_tdatab = 3'd0;
    rd_ptr    = 0;
    forever begin
      @(negedge clk);
      if (fired && tx_tvalid) rd_ptr++;
      if (rd_ptr < hq.size()) begin
        tx_tvalid = 1'b1;
        tx_tdata  = hq[rd_ptr].d;
        tx_tlast  = hq[rd_ptr].last;
        tx_tdatab = hq[rd_ptr].db;
      end else begin
        tx_tvalid = 1'b0;
      end
    end
  end

  // tx_en/tx_bit may only move right after a tx_req edge or on async reset
  logic req_d = 1'b0;
  logic en_p, bit_p, rst_p;
  always @(posedge clk) req_d <= tx_req;
  always @(negedge clk) begin
    if (rstn && rst_p && !req_d && ((tx_en !== en_p) || (tx_bit !== bit_p)))
      stab_err <= stab_err + 1;
    en_p  <= tx_en;
    bit_p <= tx_bit;
    rst_p <= rstn;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic last, input logic [2:0] db);
    hbyte_t e;
    e.d    = d;
    e.last = last;
    e.db   = db;
    hq.push_back(e);
    fq.push_back(e);
  endtask

  task automatic do_req(output logic en, output logic b, output logic dn, output logic un);
    @(negedge clk);
    tx_req = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
    en = tx_en;
    b  = tx_bit;
    dn = done;
    un = underrun;
    repeat (GAP) @(negedge clk);
  endtask

  // Model: start bit, LSB-first data, odd parity after full bytes only
  task automatic run_frame(input string name, input logic und);
    logic   q[$];
    logic   en, b, dn, un;
    hbyte_t e;
    int     n, ones;
    logic   fin;
    fin = 1'b0;
    q.push_back(1'b0);
    while (!fin && (fq.size() > 0)) begin
      e = fq.pop_front();
      n = (e.last && (e.db != 3'd0)) ? int'(e.db) : 8;
      for (int i = 0; i < n; i++) q.push_back(e.d[i]);
      if (n == 8) begin
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(e.d[i]);
        q.push_back(((ones % 2) == 0) ? 1'b1 : 1'b0);
      end
      fin = e.last;
    end
    foreach (q[i]) begin
      do_req(en, b, dn, un);
      chk($sformatf("%s_en[%0d]", name, i), en, 1'b1);
      chk($sformatf("%s_bit[%0d]", name, i), b, q[i]);
      if (i == 0) chk($sformatf("%s_busy", name), busy, 1'b1);
    end
    do_req(en, b, dn, un);
    chk($sformatf("%s_end_en", name), en, 1'b0);
    chk($sformatf("%s_done", name), dn, ~und);
    chk($sformatf("%s_underrun", name), un, und);
  endtask

  initial begin
    logic       en, b, dn, un;
    logic [7:0] d;
    logic [2:0] db;
    int         nb;

    rstn   = 1'b0;
    tx_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready", tx_tready, 1'b1);
    chk("rst_en", tx_en, 1'b0);
    chk("rst_bit", tx_bit, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    rstn = 1'b1;

    // Request with nothing queued
    do_req(en, b, dn, un);
    chk("idle_en", en, 1'b0);
    chk("idle_done", dn, 1'b0);
    chk("idle_underrun", un, 1'b0);
    chk("idle_busy", busy, 1'b0);

    push(8'h26, 1'b1, 3'd7);
    run_frame("reqa", 1'b0);

    push(8'h93, 1'b0, 3'd0);
    push(8'h20, 1'b1, 3'd0);
    run_frame("sel", 1'b0);

    // Underrun, then drain of the stale tail
    push(8'h93, 1'b0, 3'd0);
    run_frame("under", 1'b1);
    chk("drain_busy", busy, 1'b1);
    push(8'hAA, 1'b0, 3'd0);
    push(8'h55, 1'b1, 3'd0);
    fq.delete();
    @(negedge clk);
    chk("drain_ready", tx_tready, 1'b1);
    for (int k = 0; k < 50; k++) begin
      if (rd_ptr == hq.size()) break;
      @(negedge clk);
    end
    chk("drain_empty", (rd_ptr == hq.size()), 1'b1);
    repeat (2) @(negedge clk);
    chk("drain_idle", busy, 1'b0);
    push(8'h26, 1'b1, 3'd7);
    run_frame("after_under", 1'b0);

    // Asynchronous reset in the middle of the data bits
    push(8'h26, 1'b1, 3'd7);
    do_req(en, b, dn, un);
    chk("mid_start", b, 1'b0);
    do_req(en, b, dn, un);
    chk("mid_b0", b, 1'b0);
    do_req(en, b, dn, un);
    chk("mid_b1_en", en, 1'b1);
    chk("mid_b1", b, 1'b1);
    fq.delete();
    #3 rstn = 1'b0;
    #1;
    chk("arst_en", tx_en, 1'b0);
    chk("arst_bit", tx_bit, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_underrun", underrun, 1'b0);
    chk("arst_tready", tx_tready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    push(8'h26, 1'b1, 3'd7);
    run_frame("post_rst", 1'b0);

    // Back-to-back frames with the host always ready
    push(8'h26, 1'b1, 3'd7);
    push(8'hC3, 1'b0, 3'd5);
    push(8'h5A, 1'b1, 3'd3);
    run_frame("b2b_a", 1'b0);
    run_frame("b2b_b", 1'b0);

    // Random frames; tdatab on non-last bytes must be ignored
    for (int f = 0; f < 8; f++) begin
      nb = int'($urandom_range(1, 3));
      for (int j = 0; j < nb; j++) begin
        d  = 8'($urandom);
        db = 3'($urandom_range(0, 7));
        push(d, (j == nb - 1), db);
      end
      run_frame($sformatf("rnd%0d", f), 1'b0);
    end

    chk("output_stability", (stab_err == 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
